// File: rtl/svm_sched_pkg.sv
//------------------------------------------------------------------------------
// svm_sched_pkg : shared scheduler types, FSM encoding and frame-size helpers
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package svm_sched_pkg;

  localparam int WORD_W                   = 64;
  localparam int DEFAULT_MAX_DEPENDENCIES = 256;

  function automatic int calc_words(input int max_deps);
    return max_deps / WORD_W;
  endfunction

  function automatic int calc_beats(input int max_deps);
    return 1 + 2 * calc_words(max_deps);
  endfunction

  typedef enum logic [2:0] {
    S_PID   = 3'd0,
    S_RD    = 3'd1,
    S_WR    = 3'd2,
    S_HOLD  = 3'd3,
    S_DRAIN = 3'd4
  } pack_state_e;

  typedef struct packed {
    logic [WORD_W-1:0]                   program_id;
    logic [DEFAULT_MAX_DEPENDENCIES-1:0] read_deps;
    logic [DEFAULT_MAX_DEPENDENCIES-1:0] write_deps;
  } txn_t;

endpackage

`default_nettype wire

// File: rtl/txn_out_stage.sv
//------------------------------------------------------------------------------
// txn_out_stage : single-entry valid/ready output register with load-when-free
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module txn_out_stage #(
  parameter int DATA_W = 576
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_ready,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic              o_free
);

  logic              r_valid;
  logic [DATA_W-1:0] r_data;

  // Free when empty or when the current entry leaves this cycle.
  assign o_free  = !r_valid || i_ready;
  assign o_valid = r_valid;
  assign o_data  = r_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/txn_packer.sv
//------------------------------------------------------------------------------
// txn_packer : assembles 64-bit host beats into wide scheduler transactions.
// Optional statistics counters enabled by TXN_PACKER_STATS_EN.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module txn_packer
  import svm_sched_pkg::*;
#(
  parameter int MAX_DEPENDENCIES = 256
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        s_axis_tvalid,
  output logic                        s_axis_tready,
  input  logic [63:0]                 s_axis_tdata,
  input  logic                        s_axis_tlast,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic [63:0]                 m_axis_tdata_owner_programID,
  output logic [MAX_DEPENDENCIES-1:0] m_axis_tdata_read_dependencies,
  output logic [MAX_DEPENDENCIES-1:0] m_axis_tdata_write_dependencies,
  output logic                        framing_err,
  output logic [31:0]                 txn_count,
  output logic [31:0]                 err_count
);

  localparam int WORDS = calc_words(MAX_DEPENDENCIES);
  localparam int CNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int TXN_W = WORD_W + 2 * MAX_DEPENDENCIES;
  localparam logic [CNT_W-1:0] c_LAST_WORD = CNT_W'(WORDS - 1);

  pack_state_e                 r_state, w_state_nxt;
  logic [CNT_W-1:0]            r_word, w_word_nxt;
  logic [WORD_W-1:0]           r_pid;
  logic [MAX_DEPENDENCIES-1:0] r_rd, r_wr;
  logic [MAX_DEPENDENCIES-1:0] w_wr_merged, w_wr_load;
  logic                        r_err, w_err;
  logic                        w_beat, w_cap_pid, w_cap_rd, w_cap_wr;
  logic                        w_load, w_out_free;
  logic [TXN_W-1:0]            w_load_data, w_out_data;

  assign s_axis_tready = (r_state != S_HOLD);
  assign w_beat        = s_axis_tvalid && s_axis_tready;
  assign framing_err   = r_err;

  always_comb begin
    w_wr_merged = r_wr;
    w_wr_merged[r_word*WORD_W +: WORD_W] = s_axis_tdata;
  end

  // A held frame already has its final write word stored; a direct load
  // takes it straight from the bus.
  assign w_wr_load   = (r_state == S_HOLD) ? r_wr : w_wr_merged;
  assign w_load_data = {r_pid, r_rd, w_wr_load};

  always_comb begin
    w_state_nxt = r_state;
    w_word_nxt  = r_word;
    w_err       = 1'b0;
    w_cap_pid   = 1'b0;
    w_cap_rd    = 1'b0;
    w_cap_wr    = 1'b0;
    w_load      = 1'b0;
    case (r_state)
      S_PID: begin
        if (w_beat) begin
          if (s_axis_tlast) begin
            w_err = 1'b1;
          end else begin
            w_cap_pid   = 1'b1;
            w_word_nxt  = '0;
            w_state_nxt = S_RD;
          end
        end
      end
      S_RD: begin
        if (w_beat) begin
          if (s_axis_tlast) begin
            w_err       = 1'b1;
            w_state_nxt = S_PID;
          end else begin
            w_cap_rd = 1'b1;
            if (r_word == c_LAST_WORD) begin
              w_word_nxt  = '0;
              w_state_nxt = S_WR;
            end else begin
              w_word_nxt = r_word + CNT_W'(1);
            end
          end
        end
      end
      S_WR: begin
        if (w_beat) begin
          if (r_word == c_LAST_WORD) begin
            if (s_axis_tlast) begin
              w_cap_wr = 1'b1;
              if (w_out_free) begin
                w_load      = 1'b1;
                w_state_nxt = S_PID;
              end else begin
                w_state_nxt = S_HOLD;
              end
            end else begin
              w_err       = 1'b1;
              w_state_nxt = S_DRAIN;
            end
          end else if (s_axis_tlast) begin
            w_err       = 1'b1;
            w_state_nxt = S_PID;
          end else begin
            w_cap_wr   = 1'b1;
            w_word_nxt = r_word + CNT_W'(1);
          end
        end
      end
      S_HOLD: begin
        if (w_out_free) begin
          w_load      = 1'b1;
          w_state_nxt = S_PID;
        end
      end
      S_DRAIN: begin
        if (w_beat && s_axis_tlast) begin
          w_state_nxt = S_PID;
        end
      end
      default: w_state_nxt = S_PID;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_PID;
      r_word  <= '0;
      r_err   <= 1'b0;
      r_pid   <= '0;
      r_rd    <= '0;
      r_wr    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_word  <= w_word_nxt;
      r_err   <= w_err;
      if (w_cap_pid) r_pid <= s_axis_tdata;
      if (w_cap_rd)  r_rd[r_word*WORD_W +: WORD_W] <= s_axis_tdata;
      if (w_cap_wr)  r_wr <= w_wr_merged;
    end
  end

  txn_out_stage #(
    .DATA_W (TXN_W)
  ) u_out_stage (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_load),
    .i_data  (w_load_data),
    .i_ready (m_axis_tready),
    .o_valid (m_axis_tvalid),
    .o_data  (w_out_data),
    .o_free  (w_out_free)
  );

  assign {m_axis_tdata_owner_programID,
          m_axis_tdata_read_dependencies,
          m_axis_tdata_write_dependencies} = w_out_data;

`ifdef TXN_PACKER_STATS_EN
  logic [31:0] r_txn_count, r_err_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_txn_count <= 32'd0;
      r_err_count <= 32'd0;
    end else begin
      if (m_axis_tvalid && m_axis_tready) r_txn_count <= r_txn_count + 32'd1;
      if (r_err)                          r_err_count <= r_err_count + 32'd1;
    end
  end

  assign txn_count = r_txn_count;
  assign err_count = r_err_count;
`else
  assign txn_count = 32'd0;
  assign err_count = 32'd0;
`endif

endmodule

`default_nettype wire
